npc_ctrl: RTL and testbench
===========================

# npc_ctrl

Multi-cycle sequencer for the NPC RV64I core. Drives the instruction-fetch and load/store handshakes, holds the instruction register that feeds the immediate/register-field extractor, and selects which immediate format that extractor's output is used. It also issues one-cycle PC and register-file write strobes per retired instruction. It sits between the memory interfaces and the datapath (extractor, ALU, register file, PC).

## Interface
- `TIMEOUT`, default 255: maximum wait cycles in `WAIT_I` or `MEM` before entering `ERR`.
- `clk`  in  1  core clock
- `rst_n`  in  1  synchronous, active-low reset
- `ifu_req`  out  1  instruction fetch request
- `ifu_ready`  in  1  fetch request accepted
- `ifu_rvalid`  in  1  fetch data valid
- `ifu_rdata`  in  32  fetched instruction
- `inst`  out  32  instruction register, feeds extractor
- `imm_sel`  out  3  immediate select: 0 I, 1 S, 2 B, 3 U, 4 J
- `br_taken`  in  1  branch compare result from ALU, valid in `EXEC`
- `lsu_req`  out  1  data access request
- `lsu_we`  out  1  1 = store, 0 = load; valid with `lsu_req`
- `lsu_ready`  in  1  data request accepted
- `lsu_rvalid`  in  1  load data valid
- `pc_we`  out  1  PC update strobe
- `pc_sel`  out  1  0 = pc+4, 1 = computed target
- `rf_we`  out  1  register-file write strobe
- `halt`  out  1  sticky, set on ebreak
- `err`  out  1  sticky, set on illegal opcode or timeout
- `state`  out  3  debug view of the FSM state

## Operation
- States and encodings: FETCH 0, WAIT_I 1, DECODE 2, EXEC 3, MEM 4, WB 5, HALT 6, ERR 7.
- **FETCH:** `ifu_req`=1 and held until `ifu_ready`; then go to WAIT_I.
- **WAIT_I:** on `ifu_rvalid`, latch `ifu_rdata` into `inst` and go to DECODE.
- **DECODE:** classify `inst[6:0]`.
  - `inst` == 32'h00100073 goes to HALT.
  - Any other SYSTEM opcode, or any unlisted opcode, goes to ERR.
  - Everything else goes to EXEC.
- Legal opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP-IMM-32, OP, OP-32.
- `imm_sel` mapping, decoded combinationally from `inst`, held constant DECODE through WB:
  - I: LOAD, OP-IMM, OP-IMM-32, JALR
  - S: STORE
  - B: BRANCH
  - U: LUI, AUIPC
  - J: JAL
  - 0: OP and OP-32
- **EXEC:** one cycle.
  - Register `br_taken` internally.
  - LOAD or STORE goes to MEM; all others go to WB.
- **MEM:** `lsu_req`=1 with `lsu_we`=(STORE), held until `lsu_ready`.
  - Store: completes on `lsu_ready`, go to WB.
  - Load: after `lsu_ready`, wait for `lsu_rvalid`, then go to WB.
  - `lsu_rvalid` is ignored in the accept cycle.
- **WB:** one cycle, then FETCH.
  - `pc_we`=1.
  - `pc_sel`=1 for JAL, JALR, or BRANCH with registered `br_taken`=1.
  - `rf_we`=1 unless STORE or BRANCH, or `inst[11:7]`==0.
- **HALT and ERR:** absorbing; only reset exits. All request and strobe outputs are 0 in these states.
- **Timeout counter:** 8-bit minimum (width from `TIMEOUT`).
  - Cleared on entry to WAIT_I and on entry to MEM.
  - Increments each waiting cycle.
  - Reaching `TIMEOUT` before the completing event goes to ERR.

## Timing
- All outputs are Moore outputs decoded from registered state, except `imm_sel` (decoded from registered `inst`).
- While `rst_n`=0 (sampled), the next state is FETCH and all of these are 0: `inst`, internal `br_taken`, the counter, `halt`, `err`.
- During reset, all of these outputs are forced 0: `ifu_req`, `lsu_req`, `lsu_we`, `pc_we`, `pc_sel`, `rf_we`.
- `ifu_req` rises in the first cycle after `rst_n` is sampled high.
- Minimum latency per instruction, with ready and rvalid each arriving at their earliest cycle:
  - ALU, jump or branch: 5 cycles.
  - Store: 6 cycles.
  - Load: 7 cycles.
- `pc_we` and `rf_we` are exactly one cycle per retired instruction, both in WB.
- Reset asserted mid-instruction aborts it: no WB strobes, and an outstanding request drops the next cycle.
- A `ifu_rvalid` or `lsu_rvalid` arriving outside its waiting state is ignored.

## Structure
- Shared package `npc_pkg`:
  - 7-bit opcode localparams.
  - FSM state enum.
  - `imm_sel` codes.
  - The ebreak constant.
- Sub-module `npc_opdec`: combinational classifier.
  - Input: `inst`.
  - Outputs: `legal`, `is_load`, `is_store`, `is_branch`, `is_jump`, `is_ebreak`, `imm_sel`.
- `npc_ctrl` holds the FSM, the instruction register and the timeout counter.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles → all strobes 0, `state`=0; `ifu_req`=1 in the first cycle after release.
- **ADDI:** fetch 32'h00500093 (addi x1,x0,5) with ready and rvalid each arriving at their earliest cycle → `imm_sel`=0; in cycle 5 `pc_we`=1, `pc_sel`=0, `rf_we`=1.
- **Loads and stores:**
  - LD 32'h0000B103 with `lsu_ready` delayed 2 cycles → `lsu_we`=0, `rf_we` only after `lsu_rvalid`.
  - SD 32'h0020B023 → `lsu_we`=1, `rf_we`=0.
- **Branch:** BEQ 32'h00000463 with `br_taken`=1 in EXEC → `imm_sel`=2, `pc_sel`=1, `rf_we`=0. Rerun with `br_taken`=0 → `pc_sel`=0.
- **Halt and illegal opcode:**
  - ebreak 32'h00100073 → `halt`=1, `state`=6, no further `ifu_req`.
  - 32'hFFFFFFFF → `err`=1, `state`=7.
- **Timeout and abort:**
  - Withhold `ifu_rvalid` for `TIMEOUT` cycles → `err`=1.
  - Assert reset during MEM → `lsu_req` drops and the FSM returns to FETCH.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared constants for the NPC RV64I multi-cycle control path:
// opcodes, FSM state encodings, immediate-format selects and ebreak.
package npc_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned ST_W   = 3;
  localparam int unsigned IMM_W  = 3;

  localparam logic [OPC_W-1:0] OPC_LUI      = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL      = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR     = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD     = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE    = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [OPC_W-1:0] OPC_OP       = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP32     = 7'b0111011;

  localparam logic [ST_W-1:0] ST_FETCH  = 3'd0;
  localparam logic [ST_W-1:0] ST_WAIT_I = 3'd1;
  localparam logic [ST_W-1:0] ST_DECODE = 3'd2;
  localparam logic [ST_W-1:0] ST_EXEC   = 3'd3;
  localparam logic [ST_W-1:0] ST_MEM    = 3'd4;
  localparam logic [ST_W-1:0] ST_WB     = 3'd5;
  localparam logic [ST_W-1:0] ST_HALT   = 3'd6;
  localparam logic [ST_W-1:0] ST_ERR    = 3'd7;

  localparam logic [IMM_W-1:0] IMM_I = 3'd0;
  localparam logic [IMM_W-1:0] IMM_S = 3'd1;
  localparam logic [IMM_W-1:0] IMM_B = 3'd2;
  localparam logic [IMM_W-1:0] IMM_U = 3'd3;
  localparam logic [IMM_W-1:0] IMM_J = 3'd4;

  localparam logic [INST_W-1:0] INST_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/npc_opdec.sv
// Combinational opcode classifier: legality, access kind, control-flow kind
// and immediate format for the instruction register contents.
module npc_opdec
  import npc_pkg::*;
(
  input  logic [INST_W-1:0] inst,
  output logic              legal,
  output logic              is_load,
  output logic              is_store,
  output logic              is_branch,
  output logic              is_jump,
  output logic              is_ebreak,
  output logic [IMM_W-1:0]  imm_sel
);

  always_comb begin
    legal     = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    is_ebreak = (inst == INST_EBREAK);
    imm_sel   = IMM_I;
    // SYSTEM and every unlisted opcode fall to default and stay illegal
    case (inst[OPC_W-1:0])
      OPC_LUI, OPC_AUIPC: begin
        legal   = 1'b1;
        imm_sel = IMM_U;
      end
      OPC_JAL: begin
        legal   = 1'b1;
        is_jump = 1'b1;
        imm_sel = IMM_J;
      end
      OPC_JALR: begin
        legal   = 1'b1;
        is_jump = 1'b1;
        imm_sel = IMM_I;
      end
      OPC_BRANCH: begin
        legal     = 1'b1;
        is_branch = 1'b1;
        imm_sel   = IMM_B;
      end
      OPC_LOAD: begin
        legal   = 1'b1;
        is_load = 1'b1;
        imm_sel = IMM_I;
      end
      OPC_STORE: begin
        legal    = 1'b1;
        is_store = 1'b1;
        imm_sel  = IMM_S;
      end
      OPC_OP_IMM, OPC_OP_IMM32: begin
        legal   = 1'b1;
        imm_sel = IMM_I;
      end
      OPC_OP, OPC_OP32: begin
        legal   = 1'b1;
        imm_sel = IMM_I;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/npc_ctrl.sv
// Multi-cycle sequencer: fetch/load-store handshakes, instruction register,
// wait timeout and per-instruction PC / register-file write strobes.
module npc_ctrl
  import npc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ifu_req,
  input  logic              ifu_ready,
  input  logic              ifu_rvalid,
  input  logic [INST_W-1:0] ifu_rdata,
  output logic [INST_W-1:0] inst,
  output logic [IMM_W-1:0]  imm_sel,
  input  logic              br_taken,
  output logic              lsu_req,
  output logic              lsu_we,
  input  logic              lsu_ready,
  input  logic              lsu_rvalid,
  output logic              pc_we,
  output logic              pc_sel,
  output logic              rf_we,
  output logic              halt,
  output logic              err,
  output logic [ST_W-1:0]   state
);

  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [ST_W-1:0]   state_q, state_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              br_q, br_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              acc_q, acc_d;
  logic              halt_q, halt_d;
  logic              err_q, err_d;
  logic              ifu_req_q, ifu_req_d;
  logic              lsu_req_q, lsu_req_d;
  logic              lsu_we_q, lsu_we_d;
  logic              pc_we_q, pc_we_d;
  logic              pc_sel_q, pc_sel_d;
  logic              rf_we_q, rf_we_d;

  logic dec_legal, dec_load, dec_store, dec_branch, dec_jump, dec_ebreak;

  npc_opdec u_opdec (
    .inst      (inst_q),
    .legal     (dec_legal),
    .is_load   (dec_load),
    .is_store  (dec_store),
    .is_branch (dec_branch),
    .is_jump   (dec_jump),
    .is_ebreak (dec_ebreak),
    .imm_sel   (imm_sel)
  );

  // Next state plus next values of the registered Moore outputs
  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    case (state_q)
      ST_FETCH: begin
        if (ifu_ready) begin
          state_d = ST_WAIT_I;
          cnt_d   = '0;
        end
      end
      ST_WAIT_I: begin
        if (ifu_rvalid) begin
          inst_d  = ifu_rdata;
          state_d = ST_DECODE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DECODE: begin
        if (dec_ebreak)      state_d = ST_HALT;
        else if (!dec_legal) state_d = ST_ERR;
        else                 state_d = ST_EXEC;
      end
      ST_EXEC: begin
        br_d = br_taken;
        if (dec_load || dec_store) begin
          state_d = ST_MEM;
          cnt_d   = '0;
          acc_d   = 1'b0;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        // acc_q separates the request phase from the load-data phase
        if (!acc_q && lsu_ready) begin
          if (dec_store) state_d = ST_WB;
          else           acc_d   = 1'b1;
        end else if (acc_q && lsu_rvalid) begin
          state_d = ST_WB;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WB:   state_d = ST_FETCH;
      default: ;
    endcase

    ifu_req_d = (state_d == ST_FETCH);
    lsu_req_d = (state_d == ST_MEM) && !acc_d;
    lsu_we_d  = lsu_req_d && dec_store;
    pc_we_d   = (state_d == ST_WB);
    pc_sel_d  = pc_we_d && (dec_jump || (dec_branch && br_d));
    rf_we_d   = pc_we_d && !dec_store && !dec_branch && (inst_q[11:7] != 5'd0);
    halt_d    = halt_q || (state_d == ST_HALT);
    err_d     = err_q || (state_d == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      inst_q    <= '0;
      br_q      <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= 1'b0;
      halt_q    <= 1'b0;
      err_q     <= 1'b0;
      ifu_req_q <= 1'b0;
      lsu_req_q <= 1'b0;
      lsu_we_q  <= 1'b0;
      pc_we_q   <= 1'b0;
      pc_sel_q  <= 1'b0;
      rf_we_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      br_q      <= br_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      halt_q    <= halt_d;
      err_q     <= err_d;
      ifu_req_q <= ifu_req_d;
      lsu_req_q <= lsu_req_d;
      lsu_we_q  <= lsu_we_d;
      pc_we_q   <= pc_we_d;
      pc_sel_q  <= pc_sel_d;
      rf_we_q   <= rf_we_d;
    end
  end

  assign ifu_req = ifu_req_q;
  assign inst    = inst_q;
  assign lsu_req = lsu_req_q;
  assign lsu_we  = lsu_we_q;
  assign pc_we   = pc_we_q;
  assign pc_sel  = pc_sel_q;
  assign rf_we   = rf_we_q;
  assign halt    = halt_q;
  assign err     = err_q;
  assign state   = state_q;

endmodule

// File: tb/tb_npc_ctrl.sv
// Directed bench for npc_ctrl: per-scenario tasks with hand-computed
// latencies, strobes and immediate selects.
module tb_npc_ctrl;

  localparam int unsigned TO = 255;

  logic        clk;
  logic        rst_n;
  logic        ifu_req, ifu_ready, ifu_rvalid;
  logic [31:0] ifu_rdata, inst;
  logic [2:0]  imm_sel, state;
  logic        br_taken, lsu_req, lsu_we, lsu_ready, lsu_rvalid;
  logic        pc_we, pc_sel, rf_we, halt, err;

  int n_chk, n_fail;
  int wb_cyc, n_pc, n_rf, n_lsu;
  logic wb_sel, wb_rf, seen_we;
  logic [2:0] wb_imm;
  bit timed_out;

  npc_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req(ifu_req), .ifu_ready(ifu_ready), .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
    .inst(inst), .imm_sel(imm_sel), .br_taken(br_taken),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_ready(lsu_ready), .lsu_rvalid(lsu_rvalid),
    .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .halt(halt), .err(err), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    ifu_ready = 1'b0; ifu_rvalid = 1'b0; ifu_rdata = 32'h0;
    br_taken = 1'b0; lsu_ready = 1'b0; lsu_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Runs one instruction from FETCH, earliest handshakes unless delayed;
  // stray rvalids are driven outside the waiting states on purpose.
  task automatic do_inst(input logic [31:0] ins, input logic brt, input int rdy_dly, input int rv_dly);
    int cyc, mw, rw;
    bit done;
    cyc = 0; mw = 0; rw = 0; done = 0;
    wb_cyc = 0; n_pc = 0; n_rf = 0; n_lsu = 0;
    wb_sel = 1'b0; wb_rf = 1'b0; seen_we = 1'b0; wb_imm = 3'd7;
    timed_out = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      cyc++;
      if (pc_we) begin
        n_pc++; wb_cyc = cyc; wb_sel = pc_sel; wb_rf = rf_we; wb_imm = imm_sel; done = 1;
      end
      if (rf_we) n_rf++;
      if (lsu_req) begin n_lsu++; seen_we = lsu_we; end
      if (state == 3'd6 || state == 3'd7) done = 1;
      ifu_ready  = (state == 3'd0) && !done;
      ifu_rvalid = 1'b1;
      ifu_rdata  = (state == 3'd1) ? ins : 32'hFFFF_FFFF;
      br_taken   = (state == 3'd3) ? brt : !brt;
      if (state == 3'd4 && lsu_req) begin
        lsu_ready = (mw >= rdy_dly); mw++;
        lsu_rvalid = 1'b1;
      end else if (state == 3'd4) begin
        lsu_ready = 1'b0;
        lsu_rvalid = (rw >= rv_dly); rw++;
      end else begin
        lsu_ready = 1'b0;
        lsu_rvalid = 1'b1;
      end
    end
    if (!done) timed_out = 1'b1;
    idle_inputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    n_chk++; if ({ifu_req, lsu_req, lsu_we, pc_we, pc_sel, rf_we} !== 6'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 000000", {ifu_req, lsu_req, lsu_we, pc_we, pc_sel, rf_we}); end
    n_chk++; if ({state, halt, err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_state: got state=%0d halt=%b err=%b expected 0 0 0", state, halt, err); end
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (ifu_req !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_req: got %b expected 1", ifu_req); end
  endtask

  task automatic test_addi();
    do_inst(32'h0050_0093, 1'b0, 0, 0);
    n_chk++; if (timed_out) begin n_fail++; $display("FAIL addi_done: got timeout expected WB"); end
    n_chk++; if (wb_cyc !== 5) begin n_fail++; $display("FAIL addi_latency: got %0d expected 5", wb_cyc); end
    n_chk++; if ({wb_imm, wb_sel, wb_rf} !== {3'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL addi_wb: got imm=%0d sel=%b rf=%b expected 0 0 1", wb_imm, wb_sel, wb_rf); end
    n_chk++; if (n_pc !== 1 || n_rf !== 1 || n_lsu !== 0) begin
      n_fail++; $display("FAIL addi_strobes: got pc=%0d rf=%0d lsu=%0d expected 1 1 0", n_pc, n_rf, n_lsu); end
  endtask

  task automatic test_load_store();
    do_inst(32'h0000_B103, 1'b0, 0, 0);
    n_chk++; if (wb_cyc !== 7 || wb_rf !== 1'b1) begin
      n_fail++; $display("FAIL ld_fast: got cyc=%0d rf=%b expected 7 1", wb_cyc, wb_rf); end
    do_inst(32'h0000_B103, 1'b0, 2, 1);
    n_chk++; if (wb_cyc !== 10) begin n_fail++; $display("FAIL ld_slow_latency: got %0d expected 10", wb_cyc); end
    n_chk++; if ({seen_we, wb_imm, wb_rf, wb_sel} !== {1'b0, 3'd0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL ld_ctrl: got we=%b imm=%0d rf=%b sel=%b expected 0 0 1 0", seen_we, wb_imm, wb_rf, wb_sel); end
    n_chk++; if (n_lsu !== 3 || n_rf !== 1) begin
      n_fail++; $display("FAIL ld_req_cycles: got req=%0d rf=%0d expected 3 1", n_lsu, n_rf); end
    do_inst(32'h0020_B023, 1'b0, 0, 0);
    n_chk++; if (wb_cyc !== 6) begin n_fail++; $display("FAIL sd_latency: got %0d expected 6", wb_cyc); end
    n_chk++; if ({seen_we, wb_imm, wb_rf, n_rf} !== {1'b1, 3'd1, 1'b0, 32'd0}) begin
      n_fail++; $display("FAIL sd_ctrl: got we=%b imm=%0d rf=%b nrf=%0d expected 1 1 0 0", seen_we, wb_imm, wb_rf, n_rf); end
  endtask

  task automatic test_branch();
    do_inst(32'h0000_0463, 1'b1, 0, 0);
    n_chk++; if ({wb_imm, wb_sel, wb_rf} !== {3'd2, 1'b1, 1'b0} || wb_cyc !== 5) begin
      n_fail++; $display("FAIL beq_taken: got imm=%0d sel=%b rf=%b cyc=%0d expected 2 1 0 5", wb_imm, wb_sel, wb_rf, wb_cyc); end
    do_inst(32'h0000_0463, 1'b0, 0, 0);
    n_chk++; if ({wb_sel, wb_rf} !== 2'b00) begin
      n_fail++; $display("FAIL beq_not_taken: got sel=%b rf=%b expected 0 0", wb_sel, wb_rf); end
  endtask

  task automatic test_back_to_back();
    do_inst(32'h1234_52B7, 1'b0, 0, 0);
    n_chk++; if ({wb_imm, wb_sel, wb_rf} !== {3'd3, 1'b0, 1'b1} || wb_cyc !== 5) begin
      n_fail++; $display("FAIL lui: got imm=%0d sel=%b rf=%b cyc=%0d expected 3 0 1 5", wb_imm, wb_sel, wb_rf, wb_cyc); end
    do_inst(32'h0080_006F, 1'b0, 0, 0);
    n_chk++; if ({wb_imm, wb_sel, wb_rf} !== {3'd4, 1'b1, 1'b0} || wb_cyc !== 5) begin
      n_fail++; $display("FAIL jal_x0: got imm=%0d sel=%b rf=%b cyc=%0d expected 4 1 0 5", wb_imm, wb_sel, wb_rf, wb_cyc); end
    do_inst(32'h0000_80E7, 1'b0, 0, 0);
    n_chk++; if ({wb_imm, wb_sel, wb_rf} !== {3'd0, 1'b1, 1'b1} || wb_cyc !== 5) begin
      n_fail++; $display("FAIL jalr: got imm=%0d sel=%b rf=%b cyc=%0d expected 0 1 1 5", wb_imm, wb_sel, wb_rf, wb_cyc); end
  endtask

  task automatic test_halt_illegal();
    bit req_seen;
    do_inst(32'h0010_0073, 1'b0, 0, 0);
    n_chk++; if ({halt, err, state} !== {1'b1, 1'b0, 3'd6} || n_pc !== 0) begin
      n_fail++; $display("FAIL ebreak: got halt=%b err=%b state=%0d pc_we=%0d expected 1 0 6 0", halt, err, state, n_pc); end
    req_seen = 0;
    for (int k = 0; k < 6; k++) begin
      ifu_ready = 1'b1;
      @(negedge clk);
      if (ifu_req || lsu_req || pc_we || rf_we || state !== 3'd6) req_seen = 1;
    end
    n_chk++; if (req_seen) begin n_fail++; $display("FAIL halt_absorb: got activity=1 expected 0"); end
    do_reset();
    n_chk++; if ({halt, state, ifu_req} !== {1'b0, 3'd0, 1'b1}) begin
      n_fail++; $display("FAIL halt_reset: got halt=%b state=%0d req=%b expected 0 0 1", halt, state, ifu_req); end
    do_inst(32'hFFFF_FFFF, 1'b0, 0, 0);
    n_chk++; if ({err, halt, state} !== {1'b1, 1'b0, 3'd7} || n_pc !== 0) begin
      n_fail++; $display("FAIL illegal: got err=%b halt=%b state=%0d pc_we=%0d expected 1 0 7 0", err, halt, state, n_pc); end
    do_reset();
    do_inst(32'h0000_0073, 1'b0, 0, 0);
    n_chk++; if ({err, state} !== {1'b1, 3'd7}) begin
      n_fail++; $display("FAIL ecall: got err=%b state=%0d expected 1 7", err, state); end
    do_reset();
  endtask

  task automatic test_timeout();
    int cnt;
    bit retired;
    @(negedge clk);
    ifu_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      ifu_ready = 1'b0; ifu_rvalid = 1'b0;
      if (state != 3'd1) break;
      cnt++;
    end
    n_chk++; if (cnt !== int'(TO) || {err, state} !== {1'b1, 3'd7}) begin
      n_fail++; $display("FAIL fetch_timeout: got waits=%0d err=%b state=%0d expected %0d 1 7", cnt, err, state, TO); end
    do_reset();
    // rvalid on the last allowed waiting cycle must still complete
    @(negedge clk);
    ifu_ready = 1'b1;
    cnt = 0; retired = 0;
    for (int k = 0; k < 400 && !retired; k++) begin
      @(negedge clk);
      ifu_ready = 1'b0; ifu_rvalid = 1'b0;
      if (pc_we) retired = 1;
      if (state == 3'd7) break;
      if (state == 3'd1) begin
        cnt++;
        if (cnt == int'(TO)) begin ifu_rvalid = 1'b1; ifu_rdata = 32'h0050_0093; end
      end
    end
    n_chk++; if (!retired || err !== 1'b0) begin
      n_fail++; $display("FAIL fetch_last_wait: got retired=%b err=%b expected 1 0", retired, err); end
    idle_inputs();
  endtask

  task automatic test_abort();
    bit in_mem;
    in_mem = 0;
    for (int k = 0; k < 20 && !in_mem; k++) begin
      @(negedge clk);
      if (state == 3'd4 && lsu_req) in_mem = 1;
      ifu_ready  = (state == 3'd0);
      ifu_rvalid = (state == 3'd1);
      ifu_rdata  = 32'h0000_B103;
      lsu_ready  = 1'b0;
    end
    n_chk++; if (!in_mem) begin n_fail++; $display("FAIL abort_reach_mem: got 0 expected 1"); end
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    n_chk++; if ({lsu_req, pc_we, rf_we, ifu_req, state} !== {4'b0, 3'd0}) begin
      n_fail++; $display("FAIL abort_drop: got lsu=%b pc=%b rf=%b ifu=%b state=%0d expected 0 0 0 0 0",
                          lsu_req, pc_we, rf_we, ifu_req, state); end
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (ifu_req !== 1'b1) begin n_fail++; $display("FAIL abort_refetch: got %b expected 1", ifu_req); end
    do_inst(32'h0050_0093, 1'b0, 0, 0);
    n_chk++; if (wb_cyc !== 5 || n_pc !== 1 || n_rf !== 1) begin
      n_fail++; $display("FAIL abort_recover: got cyc=%0d pc=%0d rf=%0d expected 5 1 1", wb_cyc, n_pc, n_rf); end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_addi();
    test_load_store();
    test_branch();
    test_back_to_back();
    test_halt_illegal();
    test_timeout();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
